// File: rtl/wb_ram_ctrl_if.sv
// Wishbone classic slave bus bundle for wb_ram_ctrl.
// The master modport drives requests and the slave modport answers them.
interface wb_ram_ctrl_if #(
   parameter int DAT_W = 32
) ();
   logic             wb_cyc_i;
   logic             wb_stb_i;
   logic             wb_we_i;
   logic [31:0]      wb_adr_i;
   logic [DAT_W-1:0] wb_dat_i;
   logic [3:0]       wb_sel_i;
   logic [DAT_W-1:0] wb_dat_o;
   logic             wb_ack_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/wb_ram_ctrl.sv
// Wishbone slave to single-port synchronous RAM controller.
// Define WB_RAM_CTRL_SEL_EN to enable byte-lane writes through read-modify-write.
module wb_ram_ctrl #(
   parameter int ADR_W = 11,
   parameter int DAT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   wb_ram_ctrl_if.slave     wb,
   output logic [ADR_W-1:0] ram_adr_o,
   output logic [DAT_W-1:0] ram_dat_o,
   output logic             ram_we_o,
   input  logic [DAT_W-1:0] ram_dat_i
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD     = 3'd1,
`ifdef WB_RAM_CTRL_SEL_EN
      RMW_RD = 3'd2,
      RMW_WR = 3'd3,
`endif
      ACK    = 3'd4
   } state_t;

   state_t           state, state_n;
   logic [ADR_W-1:0] adr_q;
   logic [DAT_W-1:0] dat_q;
   logic [DAT_W-1:0] rd_q;
   logic             ack_q;
   logic             req;
   logic             full_wr;
`ifdef WB_RAM_CTRL_SEL_EN
   logic [3:0]       sel_q;
   logic             part_wr;
`endif
   logic             unused_bits;

   assign req = wb.wb_cyc_i & wb.wb_stb_i;

`ifdef WB_RAM_CTRL_SEL_EN
   assign full_wr     = (wb.wb_sel_i == 4'hF);
   assign part_wr     = (wb.wb_sel_i != 4'h0) && (wb.wb_sel_i != 4'hF);
   assign unused_bits = ^{wb.wb_adr_i[31:ADR_W+2], wb.wb_adr_i[1:0]};

   // Selected lanes come from the latched write data, the rest from the RAM.
   function automatic logic [DAT_W-1:0] lane_merge(input logic [DAT_W-1:0] new_d,
                                                   input logic [DAT_W-1:0] old_d,
                                                   input logic [3:0]       sel);
      logic [DAT_W-1:0] r;
      r = old_d;
      for (int n = 0; n < 4; n++) begin
         if (sel[n]) r[8*n +: 8] = new_d[8*n +: 8];
      end
      return r;
   endfunction
`else
   assign full_wr     = 1'b1;
   assign unused_bits = ^{wb.wb_adr_i[31:ADR_W+2], wb.wb_adr_i[1:0], wb.wb_sel_i};
`endif

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (req) begin
               if (!wb.wb_we_i) state_n = RD;
`ifdef WB_RAM_CTRL_SEL_EN
               else if (part_wr) state_n = RMW_RD;
`endif
               else state_n = ACK;
            end
         end
         RD:     state_n = wb.wb_cyc_i ? ACK : IDLE;
`ifdef WB_RAM_CTRL_SEL_EN
         RMW_RD: state_n = wb.wb_cyc_i ? RMW_WR : IDLE;
         RMW_WR: state_n = wb.wb_cyc_i ? ACK : IDLE;
`endif
         ACK:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // The RAM sees the live bus in IDLE so a request edge also issues the RAM access.
   always_comb begin
      ram_adr_o = adr_q;
      ram_dat_o = dat_q;
      ram_we_o  = 1'b0;
      if (state == IDLE) begin
         ram_adr_o = wb.wb_adr_i[ADR_W+1:2];
         ram_dat_o = wb.wb_dat_i;
         ram_we_o  = req & wb.wb_we_i & full_wr;
      end
`ifdef WB_RAM_CTRL_SEL_EN
      else if (state == RMW_WR) begin
         ram_dat_o = lane_merge(dat_q, ram_dat_i, sel_q);
         ram_we_o  = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         adr_q <= '0;
         dat_q <= '0;
         rd_q  <= '0;
         ack_q <= 1'b0;
`ifdef WB_RAM_CTRL_SEL_EN
         sel_q <= '0;
`endif
      end else begin
         state <= state_n;
         ack_q <= (state_n == ACK);
         if (state == IDLE && req) begin
            adr_q <= wb.wb_adr_i[ADR_W+1:2];
            dat_q <= wb.wb_dat_i;
`ifdef WB_RAM_CTRL_SEL_EN
            sel_q <= wb.wb_sel_i;
`endif
         end
         if (state == RD && wb.wb_cyc_i) rd_q <= ram_dat_i;
      end
   end

   assign wb.wb_dat_o = rd_q;
   assign wb.wb_ack_o = ack_q;

endmodule

// File: doc/wb_ram_ctrl.md
WB_RAM_CTRL -- requirements
Module: wb_ram_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter ADR_W, default 11, SHALL set the RAM word-address width.
REQ-003 Parameter DAT_W, default 32, SHALL set the data width; only 32 is supported, with 4 byte lanes.
REQ-004 Port `clk`, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 Port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-006 Port `wb_cyc_i`, input, 1 bit: Wishbone cycle valid.
REQ-007 Port `wb_stb_i`, input, 1 bit: Wishbone strobe.
REQ-008 Port `wb_we_i`, input, 1 bit: 1 = write, 0 = read.
REQ-009 Port `wb_adr_i`, input, 32 bits: byte address; word index = wb_adr_i[ADR_W+1:2]; all other bits are ignored (aliasing).
REQ-010 Port `wb_dat_i`, input, DAT_W bits: write data.
REQ-011 Port `wb_sel_i`, input, 4 bits: byte-lane enables; bit n selects bits 8n+7:8n.
REQ-012 Port `wb_dat_o`, output, DAT_W bits: registered read data.
REQ-013 Port `wb_ack_o`, output, 1 bit: registered single-cycle acknowledge.
REQ-014 Port `ram_adr_o`, output, ADR_W bits: word address to the single-port RAM.
REQ-015 Port `ram_dat_o`, output, DAT_W bits: write data to the RAM.
REQ-016 Port `ram_we_o`, output, 1 bit: RAM write enable.
REQ-017 Port `ram_dat_i`, input, DAT_W bits: RAM read data, valid one clock after the address is sampled (old data on write).

Function
REQ-018 States SHALL be IDLE, RD, RMW_RD, RMW_WR and ACK.
REQ-019 A request SHALL be wb_cyc_i & wb_stb_i sampled high in IDLE; address, data, sel and we are latched at that edge.
REQ-020 In IDLE, ram_adr_o SHALL follow wb_adr_i combinationally; in all other states it SHALL be the latched address.
REQ-021 Read: IDLE -> RD -> ACK; wb_dat_o SHALL capture ram_dat_i on the RD->ACK edge, and wb_ack_o SHALL be high during ACK, which is 2 cycles after the request edge.
REQ-022 Full write (sel = 4'hF): ram_we_o SHALL be driven combinationally in IDLE with ram_dat_o = wb_dat_i, then IDLE -> ACK; ack follows 1 cycle after the request edge.
REQ-023 Partial write (sel not 0 and not F): IDLE -> RMW_RD -> RMW_WR -> ACK.
REQ-024 During RMW_WR, ram_dat_o SHALL be the lane-merged value (selected lanes from latched data, others from ram_dat_i), with ram_we_o = 1.
REQ-025 The partial-write ack SHALL be asserted 3 cycles after the request edge.
REQ-026 Write with sel = 0: no RAM write; IDLE -> ACK; ack after 1 cycle.
REQ-027 wb_ack_o SHALL be high for exactly one cycle; ACK -> IDLE unconditionally.
REQ-028 A strobe present during ACK SHALL NOT be sampled; back-to-back requests are therefore separated by at least one IDLE cycle.
REQ-029 If wb_cyc_i drops in RD, RMW_RD or RMW_WR, the block SHALL return to IDLE without ack.
REQ-030 If wb_cyc_i drops in RMW_RD, no RAM write SHALL occur; if it drops in RMW_WR, the write SHALL still complete that cycle.
REQ-031 ram_we_o SHALL be 0 in every state except IDLE (full write) and RMW_WR.
REQ-032 wb_dat_o SHALL hold its value until the next read completes; writes SHALL NOT alter it.

Reset
REQ-033 When rst_n is low, state = IDLE, wb_ack_o = 0 and wb_dat_o = 0 immediately, asynchronously.
REQ-034 Latched address, data and sel SHALL reset to 0.
REQ-035 Reset mid-transaction SHALL abort it with no ack; a RMW_WR in progress SHALL NOT be guaranteed to write.
REQ-036 Reset release SHALL be followed by operation from the first rising edge with rst_n high.

Configuration
REQ-037 Macro WB_RAM_CTRL_SEL_EN defined: byte-select behaviour as in REQ-023 through REQ-026.
REQ-038 Macro WB_RAM_CTRL_SEL_EN undefined: wb_sel_i SHALL be ignored, every write is a full write per REQ-022, and states RMW_RD/RMW_WR SHALL NOT exist.

Verification
REQ-039 Full write then read: write 32'hDEADBEEF to adr 0x10, sel F -> ack at +1; read 0x10 -> ack at +2 with wb_dat_o = DEADBEEF.
REQ-040 Partial write: RAM word 0x11223344 at adr 0x20; write 32'hAABBCCDD with sel 4'b0101 -> ack at +3; read -> 0x11BB33DD.
REQ-041 Abort: start a sel 4'b0001 write, drop wb_cyc_i in RMW_RD -> no ack, ram_we_o never high, word unchanged.
REQ-042 Held strobe: keep stb high across 2 reads of adr 0x4 and 0x8 -> exactly 2 single-cycle acks, each preceded by an IDLE cycle.
REQ-043 Aliasing and reset: write to 0x2000 with ADR_W = 11 -> word 0 is updated; assert rst_n low during RD -> ack 0 and wb_dat_o 0 immediately.
REQ-044 Macro off: write 32'hAABBCCDD with sel 4'b0001 -> full word written, ack at +1.
